// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) unit.
// One iteration per cycle, WIDTH iterations per operation; results appear with a done pulse.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div0
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StMult, StDiv, StFinish} state_e;

    state_e           r_state;
    state_e           w_state_n;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic             r_qm1;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_div0;

    logic             w_accept;
    logic             w_div_zero;
    logic             w_launch;
    logic             w_iter;
    logic             w_last;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_booth;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_acc_n;
    logic [WIDTH-1:0] w_q_n;
    logic             w_qm1_n;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    // FINISH accepts a new start exactly like IDLE.
    assign w_accept   = ((r_state == StIdle) || (r_state == StFinish)) && start;
    assign w_div_zero = w_accept && op && (b == '0);
    assign w_launch   = w_accept && !w_div_zero;
    assign w_iter     = (r_state == StMult) || (r_state == StDiv);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    assign w_abs_a = a[WIDTH-1] ? -a : a;
    assign w_abs_b = b[WIDTH-1] ? -b : b;
    assign w_m_ext = {r_m[WIDTH-1], r_m};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            StIdle, StFinish: begin
                w_state_n = StIdle;
                if (w_launch) begin
                    w_state_n = op ? StDiv : StMult;
                end
            end
            StMult, StDiv: begin
                if (w_last) begin
                    w_state_n = StFinish;
                end
            end
            default: w_state_n = StIdle;
        endcase
    end

    // One iteration of either algorithm; the divider reuses r_acc as the partial remainder
    // and r_q as the dividend/quotient shift register.
    always_comb begin
        w_booth = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_booth = r_acc + w_m_ext;
            2'b10:   w_booth = r_acc - w_m_ext;
            default: w_booth = r_acc;
        endcase
        w_trial = {r_acc[WIDTH-1:0], r_q[WIDTH-1]} - {1'b0, r_m};
        if (r_state == StDiv) begin
            w_qm1_n = 1'b0;
            if (!w_trial[WIDTH]) begin
                w_acc_n = w_trial;
                w_q_n   = {r_q[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_n = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
                w_q_n   = {r_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_n = {w_booth[WIDTH], w_booth[WIDTH:1]};
            w_q_n   = {w_booth[0], r_q[WIDTH-1:1]};
            w_qm1_n = r_q[0];
        end
    end

    assign w_quo = r_neg_q ? -w_q_n : w_q_n;
    assign w_rem = r_neg_r ? -w_acc_n[WIDTH-1:0] : w_acc_n[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_qm1   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            if (w_launch) begin
                r_cnt   <= '0;
                r_acc   <= '0;
                r_qm1   <= 1'b0;
                r_q     <= op ? w_abs_a : a;
                r_m     <= op ? w_abs_b : b;
                r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                r_neg_r <= a[WIDTH-1];
            end else if (w_iter) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= w_acc_n;
                r_q   <= w_q_n;
                r_qm1 <= w_qm1_n;
                if (w_last) begin
                    r_done <= 1'b1;
                    if (r_state == StDiv) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_acc_n[WIDTH-1:0];
                        r_lo <= w_q_n;
                    end
                end
            end
            if (w_div_zero) begin
                r_done <= 1'b1;
                r_div0 <= 1'b1;
            end
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = w_iter;
    assign done = r_done;
    assign div0 = r_div0;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomised bench for mult_div_unit at WIDTH 8, 16 and 32.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start_bus;
    logic        op_bus;
    logic [63:0] a_bus;
    logic [63:0] b_bus;
    int          sel_w;

    logic [7:0]  hi8, lo8;
    logic [15:0] hi16, lo16;
    logic [31:0] hi32, lo32;
    logic        busy8, done8, div08;
    logic        busy16, done16, div016;
    logic        busy32, done32, div032;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start_bus && (sel_w == 8)), .op(op_bus),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .hi(hi8), .lo(lo8),
        .busy(busy8), .done(done8), .div0(div08)
    );
    mult_div_unit #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .start(start_bus && (sel_w == 16)), .op(op_bus),
        .a(a_bus[15:0]), .b(b_bus[15:0]), .hi(hi16), .lo(lo16),
        .busy(busy16), .done(done16), .div0(div016)
    );
    mult_div_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .start(start_bus && (sel_w == 32)), .op(op_bus),
        .a(a_bus[31:0]), .b(b_bus[31:0]), .hi(hi32), .lo(lo32),
        .busy(busy32), .done(done32), .div0(div032)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] get_hi(input int w);
        case (w)
            8:       return {56'd0, hi8};
            16:      return {48'd0, hi16};
            default: return {32'd0, hi32};
        endcase
    endfunction

    function automatic logic [63:0] get_lo(input int w);
        case (w)
            8:       return {56'd0, lo8};
            16:      return {48'd0, lo16};
            default: return {32'd0, lo32};
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            8:       return done8;
            16:      return done16;
            default: return done32;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            8:       return busy8;
            16:      return busy16;
            default: return busy32;
        endcase
    endfunction

    function automatic longint sext(input logic [63:0] v, input int w);
        longint t;
        t = longint'(v << (64 - w));
        return t >>> (64 - w);
    endfunction

    // Reference: full signed product, or C-style truncating quotient and remainder.
    task automatic model(input int w, input logic o, input logic [63:0] av, input logic [63:0] bv,
                         output logic [63:0] eh, output logic [63:0] el);
        longint sa, sb, r;
        logic [63:0] mask;
        sa   = sext(av, w);
        sb   = sext(bv, w);
        mask = (64'd1 << w) - 64'd1;
        if (!o) begin
            r  = sa * sb;
            el = 64'(r) & mask;
            eh = 64'(r >>> w) & mask;
        end else begin
            el = 64'(sa / sb) & mask;
            eh = 64'(sa % sb) & mask;
        end
    endtask

    task automatic launch(input int w, input logic o, input logic [63:0] av,
                          input logic [63:0] bv);
        sel_w     = w;
        op_bus    = o;
        a_bus     = av;
        b_bus     = bv;
        start_bus = 1'b1;
        tick();
        start_bus = 1'b0;
    endtask

    // Waits (bounded) for done; optionally scrambles start/op/a/b while the unit is busy.
    task automatic wait_done(input int w, input bit toggle, output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (get_done(w) !== 1'b1 && lat < 200) begin
            if (get_busy(w) === 1'b1) busy_cnt++;
            if (toggle) begin
                start_bus = 1'($urandom_range(0, 1));
                op_bus    = 1'($urandom_range(0, 1));
                a_bus     = {$urandom, $urandom};
                b_bus     = {$urandom, $urandom};
            end
            tick();
            lat++;
        end
        start_bus = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total_cnt++; if (hi32 !== 32'h0) $display("FAIL rst_hi got %h want 0", hi32); else pass_cnt++;
        total_cnt++; if (lo32 !== 32'h0) $display("FAIL rst_lo got %h want 0", lo32); else pass_cnt++;
        total_cnt++; if (busy32 !== 1'b0) $display("FAIL rst_busy got %b want 0", busy32); else pass_cnt++;
        total_cnt++; if (done32 !== 1'b0) $display("FAIL rst_done got %b want 0", done32); else pass_cnt++;
        total_cnt++; if (div032 !== 1'b0) $display("FAIL rst_div0 got %b want 0", div032); else pass_cnt++;
        total_cnt++; if ({hi8, lo8} !== 16'h0) $display("FAIL rst8 got %h want 0", {hi8, lo8}); else pass_cnt++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mult();
        int lat, bc;
        launch(32, 1'b0, 64'hFFFF_FFFD, 64'd7);
        wait_done(32, 1'b0, lat, bc);
        total_cnt++; if (lat != 32) $display("FAIL mul_lat got %0d want 32", lat); else pass_cnt++;
        total_cnt++; if (bc != 32) $display("FAIL mul_busy_cycles got %0d want 32", bc); else pass_cnt++;
        total_cnt++; if (hi32 !== 32'hFFFF_FFFF) $display("FAIL mul_hi got %h want ffffffff", hi32); else pass_cnt++;
        total_cnt++; if (lo32 !== 32'hFFFF_FFEB) $display("FAIL mul_lo got %h want ffffffeb", lo32); else pass_cnt++;
        total_cnt++; if (busy32 !== 1'b0) $display("FAIL mul_busy_done got %b want 0", busy32); else pass_cnt++;
        tick();
        total_cnt++; if (done32 !== 1'b0) $display("FAIL mul_done_width got %b want 0", done32); else pass_cnt++;

        launch(32, 1'b0, 64'h8000_0000, 64'h8000_0000);
        wait_done(32, 1'b0, lat, bc);
        total_cnt++; if ({hi32, lo32} !== 64'h4000_0000_0000_0000)
            $display("FAIL mul_minmin got %h want 4000000000000000", {hi32, lo32}); else pass_cnt++;

        launch(32, 1'b0, 64'h7FFF_FFFF, 64'h7FFF_FFFF);
        wait_done(32, 1'b0, lat, bc);
        total_cnt++; if ({hi32, lo32} !== 64'h3FFF_FFFF_0000_0001)
            $display("FAIL mul_maxmax got %h want 3fffffff00000001", {hi32, lo32}); else pass_cnt++;
    endtask

    task automatic test_div();
        int lat, bc;
        launch(32, 1'b1, 64'hFFFF_FFF9, 64'd2);
        wait_done(32, 1'b0, lat, bc);
        total_cnt++; if (lat != 32) $display("FAIL div_lat got %0d want 32", lat); else pass_cnt++;
        total_cnt++; if (lo32 !== 32'hFFFF_FFFD) $display("FAIL div_q_neg got %h want fffffffd", lo32); else pass_cnt++;
        total_cnt++; if (hi32 !== 32'hFFFF_FFFF) $display("FAIL div_r_neg got %h want ffffffff", hi32); else pass_cnt++;

        launch(32, 1'b1, 64'd100, 64'd7);
        wait_done(32, 1'b0, lat, bc);
        total_cnt++; if ({hi32, lo32} !== {32'd2, 32'd14})
            $display("FAIL div_pos got %h want 000000020000000e", {hi32, lo32}); else pass_cnt++;

        launch(32, 1'b1, 64'd7, 64'hFFFF_FFFE);
        wait_done(32, 1'b0, lat, bc);
        total_cnt++; if ({hi32, lo32} !== {32'd1, 32'hFFFF_FFFD})
            $display("FAIL div_negdiv got %h want 00000001fffffffd", {hi32, lo32}); else pass_cnt++;
    endtask

    task automatic test_div0();
        launch(32, 1'b1, 64'd5, 64'd0);
        total_cnt++; if (div032 !== 1'b1) $display("FAIL dz_div0 got %b want 1", div032); else pass_cnt++;
        total_cnt++; if (done32 !== 1'b1) $display("FAIL dz_done got %b want 1", done32); else pass_cnt++;
        total_cnt++; if (busy32 !== 1'b0) $display("FAIL dz_busy got %b want 0", busy32); else pass_cnt++;
        total_cnt++; if ({hi32, lo32} !== {32'd1, 32'hFFFF_FFFD})
            $display("FAIL dz_hold got %h want 00000001fffffffd", {hi32, lo32}); else pass_cnt++;
        tick();
        total_cnt++; if ({done32, div032} !== 2'b00)
            $display("FAIL dz_pulse got %b want 00", {done32, div032}); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        launch(8, 1'b1, 64'h80, 64'hFF);
        wait_done(8, 1'b0, lat, bc);
        total_cnt++; if (lat != 8) $display("FAIL ovf_lat got %0d want 8", lat); else pass_cnt++;
        total_cnt++; if ({hi8, lo8} !== 16'h0080) $display("FAIL ovf_res got %h want 0080", {hi8, lo8}); else pass_cnt++;
        total_cnt++; if (div08 !== 1'b0) $display("FAIL ovf_div0 got %b want 0", div08); else pass_cnt++;
        // Start held during FINISH: must launch immediately.
        op_bus    = 1'b0;
        a_bus     = 64'h05;
        b_bus     = 64'hFD;
        start_bus = 1'b1;
        tick();
        start_bus = 1'b0;
        total_cnt++; if (busy8 !== 1'b1) $display("FAIL b2b_accept got %b want 1", busy8); else pass_cnt++;
        wait_done(8, 1'b0, lat, bc);
        total_cnt++; if (lat != 8) $display("FAIL b2b_lat got %0d want 8", lat); else pass_cnt++;
        total_cnt++; if ({hi8, lo8} !== 16'hFFF1) $display("FAIL b2b_res got %h want fff1", {hi8, lo8}); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat, bc, extra;
        launch(32, 1'b0, 64'hFFFF_FFFD, 64'd7);
        repeat (9) tick();
        total_cnt++; if ({hi32, lo32} !== {32'd1, 32'hFFFF_FFFD})
            $display("FAIL mid_hold got %h want 00000001fffffffd", {hi32, lo32}); else pass_cnt++;
        total_cnt++; if (busy32 !== 1'b1) $display("FAIL mid_busy got %b want 1", busy32); else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++; if ({hi32, lo32, busy32, done32, div032} !== 67'd0)
            $display("FAIL mid_rst got %h want 0", {hi32, lo32, busy32, done32, div032}); else pass_cnt++;
        extra = 0;
        repeat (40) begin
            tick();
            if (done32 === 1'b1) extra++;
        end
        total_cnt++; if (extra != 0) $display("FAIL mid_no_done got %0d want 0", extra); else pass_cnt++;
        launch(32, 1'b0, 64'hFFFF_FFFD, 64'd7);
        wait_done(32, 1'b0, lat, bc);
        total_cnt++; if (lat != 32) $display("FAIL mid_relat got %0d want 32", lat); else pass_cnt++;
        total_cnt++; if ({hi32, lo32} !== 64'hFFFF_FFFF_FFFF_FFEB)
            $display("FAIL mid_rerun got %h want ffffffffffffffeb", {hi32, lo32}); else pass_cnt++;
    endtask

    task automatic test_random();
        int ws[3] = '{8, 16, 32};
        int lat, bc;
        logic o;
        logic [63:0] av, bv, eh, el, mask;
        foreach (ws[i]) begin
            mask = (64'd1 << ws[i]) - 64'd1;
            repeat (6) begin
                o  = 1'($urandom_range(0, 1));
                av = {$urandom, $urandom} & mask;
                bv = {$urandom, $urandom} & mask;
                if (bv == 64'd0) bv = 64'd1;
                model(ws[i], o, av, bv, eh, el);
                launch(ws[i], o, av, bv);
                wait_done(ws[i], 1'b1, lat, bc);
                total_cnt++; if (lat != ws[i])
                    $display("FAIL rnd_lat w%0d got %0d want %0d", ws[i], lat, ws[i]); else pass_cnt++;
                total_cnt++; if (get_hi(ws[i]) !== eh)
                    $display("FAIL rnd_hi w%0d op%0d a=%h b=%h got %h want %h",
                             ws[i], o, av, bv, get_hi(ws[i]), eh); else pass_cnt++;
                total_cnt++; if (get_lo(ws[i]) !== el)
                    $display("FAIL rnd_lo w%0d op%0d a=%h b=%h got %h want %h",
                             ws[i], o, av, bv, get_lo(ws[i]), el); else pass_cnt++;
                tick();
                total_cnt++; if ({get_done(ws[i]), get_busy(ws[i])} !== 2'b00)
                    $display("FAIL rnd_ignored w%0d got %b want 00", ws[i],
                             {get_done(ws[i]), get_busy(ws[i])}); else pass_cnt++;
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        start_bus = 1'b0;
        op_bus    = 1'b0;
        a_bus     = '0;
        b_bus     = '0;
        sel_w     = 32;
        test_reset();
        test_mult();
        test_div();
        test_div0();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
